// File: rtl/restoring_divider_16by8.sv
// 16-by-8 unsigned restoring divider with a valid/ready handshake on both
// sides. One quotient bit is resolved per CALC cycle, MSB first.
module restoring_divider_16by8 (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  iter_cnt;
  logic [7:0]  part_rem;
  logic [15:0] shift_reg;  // dividend bits shift out the top, quotient bits in the bottom
  logic [7:0]  dvs_reg;
  logic        zero_op;

  logic        accept;
  logic        last_step;
  logic [8:0]  trial;
  logic        take;
  logic [7:0]  rem_step;

  // One restoring step on the current partial remainder and next dividend bit.
  // When take is set the difference is below the divisor, so 8 bits suffice.
  always_comb begin
    accept    = in_valid && (state == IDLE);
    last_step = (iter_cnt == 5'd15);
    trial     = {part_rem, shift_reg[15]};
    take      = (trial >= {1'b0, dvs_reg});
    rem_step  = take ? (trial[7:0] - dvs_reg) : trial[7:0];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_step) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Operand capture, iteration datapath and result registers.
  // A zero divisor enters CALC with the counter preset to its last value, so it
  // spends a single cycle there and reaches DONE one edge after accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt  <= '0;
      part_rem  <= '0;
      shift_reg <= '0;
      dvs_reg   <= '0;
      zero_op   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= dividend;
            dvs_reg   <= divisor;
            part_rem  <= '0;
            zero_op   <= (divisor == '0);
            iter_cnt  <= (divisor == '0) ? 5'd15 : 5'd0;
          end
        end
        CALC: begin
          iter_cnt <= iter_cnt + 5'd1;
          if (!zero_op) begin
            part_rem  <= rem_step;
            shift_reg <= {shift_reg[14:0], take};
          end
          if (last_step) begin
            if (zero_op) begin
              quotient  <= '1;
              remainder <= shift_reg[7:0];
              div_zero  <= 1'b1;
            end else begin
              quotient  <= {shift_reg[14:0], take};
              remainder <= rem_step;
              div_zero  <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_restoring_divider_16by8.sv
// Directed and random checks for restoring_divider_16by8.
module tb_restoring_divider_16by8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_zero;

  int unsigned total;
  int unsigned bad;

  restoring_divider_16by8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation, wait for the result, check latency and fields, retire it.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] exp_q, input logic [7:0] exp_r,
                       input logic exp_z, input int exp_lat, input string name);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL %s in_ready_wait: got %0b want 1", name, in_ready);
    end
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dividend = 16'hDEAD;
    divisor  = 8'hBE;
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    total++;
    if (lat !== exp_lat) begin
      bad++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    total++;
    if (quotient !== exp_q || remainder !== exp_r || div_zero !== exp_z) begin
      bad++;
      $display("FAIL %s result: got q=%0d r=%0d z=%0b want q=%0d r=%0d z=%0b",
               name, quotient, remainder, div_zero, exp_q, exp_r, exp_z);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL %s retire: got in_ready=%0b out_valid=%0b want 1 0",
               name, in_ready, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
        remainder !== 8'd0 || div_zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: got in_ready=%0b out_valid=%0b q=%0d r=%0d z=%0b want 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    do_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 16, "basic_1000_7");
    do_op(16'd200, 8'd9, 16'd22, 8'd2, 1'b0, 16, "basic_200_9");
  endtask

  task automatic test_boundary();
    do_op(16'd65535, 8'd1, 16'd65535, 8'd0, 1'b0, 16, "bnd_65535_1");
    do_op(16'd100, 8'd200, 16'd0, 8'd100, 1'b0, 16, "bnd_100_200");
    do_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 16, "bnd_65535_255");
    do_op(16'd0, 8'd5, 16'd0, 8'd0, 1'b0, 16, "bnd_0_5");
    do_op(16'd254, 8'd255, 16'd0, 8'd254, 1'b0, 16, "bnd_254_255");
  endtask

  task automatic test_div_zero();
    do_op(16'h1234, 8'd0, 16'hFFFF, 8'h34, 1'b1, 1, "divzero_1234");
    do_op(16'h00FF, 8'd0, 16'hFFFF, 8'hFF, 1'b1, 1, "divzero_00ff");
  endtask

  task automatic test_backpressure();
    int guard;
    dividend = 16'd200;
    divisor  = 8'd9;
    in_valid = 1'b1;
    tick();
    dividend = 16'd7;
    divisor  = 8'd2;
    guard = 0;
    while (!out_valid && guard < 40) begin
      tick();
      guard++;
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || quotient !== 16'd22 ||
          remainder !== 8'd2 || div_zero !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold[%0d]: got ov=%0b ir=%0b q=%0d r=%0d z=%0b want 1 0 22 2 0",
                 i, out_valid, in_ready, quotient, remainder, div_zero);
      end
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got in_ready=%0b out_valid=%0b want 1 0", in_ready, out_valid);
    end
    tick();
    tick();
    total++;
    if (quotient !== 16'd22 || remainder !== 8'd2 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_idle_hold: got q=%0d r=%0d ov=%0b want 22 2 0", quotient, remainder, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    dividend = 16'd5000;
    divisor  = 8'd3;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    rst = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || quotient !== 16'd0 ||
        remainder !== 8'd0 || div_zero !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: got ir=%0b ov=%0b q=%0d r=%0d z=%0b want 1 0 0 0 0",
               in_ready, out_valid, quotient, remainder, div_zero);
    end
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (out_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_no_result: got %0d valid cycles want 0", seen);
    end
    do_op(16'd5000, 8'd3, 16'd1666, 8'd2, 1'b0, 16, "rst_after_5000_3");
  endtask

  // Edges between the first two accepts with in_valid and out_ready held high.
  task automatic measure_ii(input logic [15:0] a, input logic [7:0] b,
                            input int exp_ii, input string name);
    int first;
    int second;
    logic acc;
    first  = -1;
    second = -1;
    dividend  = a;
    divisor   = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 60 && second < 0; i++) begin
      acc = in_ready && in_valid;
      tick();
      if (acc) begin
        if (first < 0) first = i;
        else second = i;
      end
    end
    in_valid  = 1'b0;
    total++;
    if (second - first !== exp_ii) begin
      bad++;
      $display("FAIL %s ii: got %0d want %0d", name, second - first, exp_ii);
    end
    repeat (20) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    measure_ii(16'd1000, 8'd7, 18, "b2b_nonzero");
    measure_ii(16'd1000, 8'd0, 3, "b2b_zero");
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  b;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    int guard;
    for (int n = 0; n < 2000; n++) begin
      a = 16'($urandom);
      b = (n % 17 == 0) ? 8'd0 : 8'($urandom);
      if (b == 8'd0) begin
        eq = 16'hFFFF;
        er = a[7:0];
        ez = 1'b1;
      end else begin
        eq = a / {8'd0, b};
        er = 8'(a % {8'd0, b});
        ez = 1'b0;
      end
      guard = 0;
      while (!in_ready && guard < 50) begin
        tick();
        guard++;
      end
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      guard = 0;
      while (!out_valid && guard < 40) begin
        tick();
        guard++;
      end
      repeat ($urandom_range(0, 3)) tick();
      total++;
      if (out_valid !== 1'b1 || quotient !== eq || remainder !== er || div_zero !== ez) begin
        bad++;
        $display("FAIL rand[%0d] %0d/%0d: got ov=%0b q=%0d r=%0d z=%0b want 1 %0d %0d %0b",
                 n, a, b, out_valid, quotient, remainder, div_zero, eq, er, ez);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_div_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
